// File: rtl/imm_ext_pipe.sv
// Immediate-generation unit: extends a raw instruction immediate to a full
// operand (zero/sign/upper/branch) and queues the result with its tag in a
// 2-entry output buffer so a stalled consumer can apply backpressure.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. A producer holds valid and its payload steady until that edge.
// in_ready depends only on the registered occupancy (and reset), never on
// in_valid or out_ready.
module imm_ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int EXT_W = OUT_W - IN_W;

    // Head entry drives the outputs directly; tail holds the second entry.
    logic [OUT_W-1:0] r_head_imm;
    logic [TAG_W-1:0] r_head_tag;
    logic [OUT_W-1:0] r_tail_imm;
    logic [TAG_W-1:0] r_tail_tag;
    logic [1:0]       r_count;

    logic [OUT_W-1:0] w_sx;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    assign w_sx = {{EXT_W{in_imm[IN_W-1]}}, in_imm};

    // Select the extended operand for the requested mode.
    always_comb begin
        w_ext = {{EXT_W{1'b0}}, in_imm};
        case (in_mode)
            2'd0: w_ext = {{EXT_W{1'b0}}, in_imm};
            2'd1: w_ext = w_sx;
            2'd2: w_ext = {in_imm, {EXT_W{1'b0}}};
            2'd3: w_ext = w_sx << BR_SHIFT;
            default: w_ext = {{EXT_W{1'b0}}, in_imm};
        endcase
    end

    // Ready is held low during reset so nothing is accepted until release.
    assign in_ready  = rst_n & (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_imm   = r_head_imm;
    assign out_tag   = r_head_tag;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // Buffer update: the head keeps its last value when the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_imm <= '0;
            r_head_tag <= '0;
            r_tail_imm <= '0;
            r_tail_tag <= '0;
            r_count    <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_imm <= w_ext;
                        r_head_tag <= in_tag;
                    end else begin
                        r_tail_imm <= w_ext;
                        r_tail_tag <= in_tag;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_imm <= r_tail_imm;
                        r_head_tag <= r_tail_tag;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1: the new entry replaces the head.
                    r_head_imm <= w_ext;
                    r_head_tag <= in_tag;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe (IN_W=16, OUT_W=32, BR_SHIFT=2, TAG_W=5).
module tb_imm_ext_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;

    int checks;
    int failures;
    int pops;

    logic [36:0] exp_q[$];

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[7];

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag)
    );

    // clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference extension model
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] sx;
        sx = {{16{imm[15]}}, imm};
        case (mode)
            2'd0: return {16'h0000, imm};
            2'd1: return sx;
            2'd2: return {imm, 16'h0000};
            default: return {sx[29:0], 2'b00};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle. At the falling edge the handshakes that will complete at
    // the next rising edge are observed: accepted inputs push to the scoreboard,
    // outputs being taken are popped and compared. Returns 1 time unit after
    // the rising edge, where the caller drives new inputs.
    task automatic cycle();
        logic [36:0] e;
        @(negedge clk);
        if (in_valid && in_ready)
            exp_q.push_back({ref_ext(in_imm, in_mode), in_tag});
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got imm 0x%08h tag %0d with nothing expected", out_imm, out_tag);
            end else begin
                e = exp_q.pop_front();
                chk("sb_imm", out_imm, e[36:5]);
                chk("sb_tag", {27'd0, out_tag}, {27'd0, e[4:0]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    initial begin
        logic [31:0] held_imm;
        logic [15:0] r_imm;
        logic [1:0]  r_mode;
        int          pops_before;

        checks    = 0;
        failures  = 0;
        pops      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        vt[0] = '{imm: 16'h8001, mode: 2'd0, tag: 5'd1, exp: 32'h0000_8001};
        vt[1] = '{imm: 16'h8001, mode: 2'd1, tag: 5'd2, exp: 32'hFFFF_8001};
        vt[2] = '{imm: 16'h8001, mode: 2'd2, tag: 5'd3, exp: 32'h8001_0000};
        vt[3] = '{imm: 16'h8001, mode: 2'd3, tag: 5'd4, exp: 32'hFFFE_0004};
        vt[4] = '{imm: 16'h7FFF, mode: 2'd1, tag: 5'd5, exp: 32'h0000_7FFF};
        vt[5] = '{imm: 16'h7FFF, mode: 2'd3, tag: 5'd6, exp: 32'h0001_FFFC};
        vt[6] = '{imm: 16'hFFFF, mode: 2'd3, tag: 5'd7, exp: 32'hFFFF_FFFC};

        // reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // table: mode sweep and sign corners, one cycle latency each
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].imm, vt[i].mode, vt[i].tag);
            chk("tbl_model", ref_ext(vt[i].imm, vt[i].mode), vt[i].exp);
            cycle();
            in_valid = 1'b0;
            chk("tbl_lat_valid", {31'd0, out_valid}, 32'd1);
            chk("tbl_imm", out_imm, vt[i].exp);
            chk("tbl_tag", {27'd0, out_tag}, {27'd0, vt[i].tag});
            cycle();
            chk("tbl_drained", {31'd0, out_valid}, 32'd0);
        end

        // backpressure: fill both entries, third request held upstream
        out_ready = 1'b0;
        drive(16'h1234, 2'd0, 5'd1);
        cycle();
        chk("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
        drive(16'h8000, 2'd1, 5'd2);
        cycle();
        chk("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
        drive(16'h0F0F, 2'd2, 5'd3);
        held_imm = out_imm;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_tag_stable", {27'd0, out_tag}, 32'd1);
            chk("bp_imm_stable", out_imm, held_imm);
            chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_ready_reassert", {31'd0, in_ready}, 32'd1);
        chk("bp_head_tag2", {27'd0, out_tag}, 32'd2);
        // simultaneous push (tag 3) and pop (tag 2) at count 1
        cycle();
        in_valid = 1'b0;
        chk("pp_valid", {31'd0, out_valid}, 32'd1);
        chk("pp_head_tag3", {27'd0, out_tag}, 32'd3);
        chk("pp_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("hold_last_tag", {27'd0, out_tag}, 32'd3);
        chk("hold_last_imm", out_imm, 32'h0F0F_0000);

        // streaming: 8 back-to-back requests, one result per cycle
        pops_before = pops;
        for (int i = 0; i < 8; i++) begin
            r_imm  = 16'($urandom_range(0, 65535));
            r_mode = 2'($urandom_range(0, 3));
            drive(r_imm, r_mode, 5'(10 + i));
            cycle();
            chk("st_in_ready", {31'd0, in_ready}, 32'd1);
            chk("st_out_valid", {31'd0, out_valid}, 32'd1);
            chk("st_tag", {27'd0, out_tag}, 32'(10 + i));
        end
        in_valid = 1'b0;
        cycle();
        chk("st_pop_count", 32'(pops - pops_before), 32'd8);
        chk("st_empty", {31'd0, out_valid}, 32'd0);

        // reset mid-operation with two entries buffered
        out_ready = 1'b0;
        drive(16'hAAAA, 2'd1, 5'd20);
        cycle();
        drive(16'h5555, 2'd2, 5'd21);
        cycle();
        in_valid = 1'b0;
        chk("mr_full", {31'd0, in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_out_imm", out_imm, 32'd0);
        chk("mr_out_tag", {27'd0, out_tag}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("mr_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_rel_out_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("mr_still_empty", {31'd0, out_valid}, 32'd0);
        drive(16'h0001, 2'd3, 5'd30);
        cycle();
        in_valid = 1'b0;
        chk("mr_new_valid", {31'd0, out_valid}, 32'd1);
        chk("mr_new_imm", out_imm, 32'h0000_0004);
        cycle();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // overall time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
